branch_resolve_unit: RTL and testbench

Pipelined, parametrised branch resolution unit for the RV32I core. It evaluates the six RV32I conditional-branch comparisons, computes the redirect PC and detects mispredictions. It also trains a direct-mapped table of 2-bit saturating counters that the fetch stage reads for predictions. It sits between decode/execute and the PC-select logic and exchanges results through valid/ready handshakes.

---
 rtl/branch_resolve_unit.sv | 132 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// RV32I branch resolution: condition compare, redirect PC, mispredict detect and
// 2-bit BHT training on retirement. Retirement statistics are built only with BRU_STATS_EN.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int PC_LSB    = 2
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      fun3,
  input  logic            pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic            out_mispredict,
  output logic [XLEN-1:0] out_redirect_pc,
  output logic            out_illegal,
  input  logic [XLEN-1:0] q_pc,
  output logic            q_taken,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);
  localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  // Only the table index of the branch PC is kept; that is all training needs.
  typedef struct packed {
    logic            taken;
    logic            mispredict;
    logic            illegal;
    logic [XLEN-1:0] redirect_pc;
    logic [IDX_W-1:0] idx;
  } res_t;

  res_t       res_d, res_q;
  logic       vld_q, accept, retire;
  logic       eq, lt, ltu, cond, illegal;
  logic [1:0] bht [BHT_DEPTH];
  logic [IDX_W-1:0] q_idx;
  logic       unused_q_pc;

  assign eq  = (op_a == op_b);
  assign lt  = ($signed(op_a) < $signed(op_b));
  assign ltu = (op_a < op_b);

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (fun3)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt;
      3'b101:  cond = !lt;
      3'b110:  cond = ltu;
      3'b111:  cond = !ltu;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    res_d             = '0;
    res_d.taken       = cond;
    res_d.illegal     = illegal;
    res_d.mispredict  = illegal || (cond != pred_taken);
    res_d.redirect_pc = cond ? (pc + imm) : (pc + XLEN'(4));
    res_d.idx         = pc[PC_LSB +: IDX_W];
  end

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign retire   = vld_q && out_ready;

  // A new request replaces a retiring one in the same edge, so no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      res_q <= '0;
    end else if (accept) begin
      vld_q <= 1'b1;
      res_q <= res_d;
    end else if (retire) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid       = vld_q;
  assign out_taken       = res_q.taken;
  assign out_mispredict  = res_q.mispredict;
  assign out_illegal     = res_q.illegal;
  assign out_redirect_pc = res_q.redirect_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (retire && !res_q.illegal) begin
      if (res_q.taken && bht[res_q.idx] != 2'b11)
        bht[res_q.idx] <= bht[res_q.idx] + 2'b01;
      else if (!res_q.taken && bht[res_q.idx] != 2'b00)
        bht[res_q.idx] <= bht[res_q.idx] - 2'b01;
    end
  end

  assign q_idx       = q_pc[PC_LSB +: IDX_W];
  assign q_taken     = bht[q_idx][1];
  assign unused_q_pc = ^q_pc;

`ifdef BRU_STATS_EN
  logic [31:0] n_br, n_mp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_br <= '0;
      n_mp <= '0;
    end else if (retire) begin
      if (n_br != 32'hFFFF_FFFF) n_br <= n_br + 32'd1;
      if (res_q.mispredict && n_mp != 32'hFFFF_FFFF) n_mp <= n_mp + 32'd1;
    end
  end

  assign stat_branches    = n_br;
  assign stat_mispredicts = n_mp;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized bench for branch_resolve_unit against a behavioural model of results,
// counter table and statistics; directed sequences cover the listed corner cases.
module tb_branch_resolve_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 0, in_ready, pred_taken = 0;
  logic [31:0] pc = 0, op_a = 0, op_b = 0, imm = 0, q_pc = 0;
  logic [2:0]  fun3 = 0;
  logic        out_valid, out_ready = 1, out_taken, out_mispredict, out_illegal, q_taken;
  logic [31:0] out_redirect_pc, stat_branches, stat_mispredicts;

  int n_cmp = 0, n_err = 0;

  // model state
  bit          m_v, m_tk, m_il, m_mp;
  logic [31:0] m_rd;
  int          m_idx;
  int          ctr [16];
  longint      m_nb, m_nm;

  branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(16), .PC_LSB(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc(pc),
    .op_a(op_a), .op_b(op_b), .imm(imm), .fun3(fun3), .pred_taken(pred_taken),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_mispredict(out_mispredict), .out_redirect_pc(out_redirect_pc),
    .out_illegal(out_illegal), .q_pc(q_pc), .q_taken(q_taken),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int tidx(input logic [31:0] a);
    return int'((a >> 2) % 16);
  endfunction

  task automatic model_reset();
    m_v = 0; m_tk = 0; m_il = 0; m_mp = 0; m_rd = 0; m_idx = 0;
    m_nb = 0; m_nm = 0;
    for (int i = 0; i < 16; i++) ctr[i] = 1;
  endtask

  task automatic check_outs();
    chk("out_valid", out_valid, m_v);
    chk("in_ready", in_ready, !m_v || out_ready);
    chk("q_taken", q_taken, ctr[tidx(q_pc)] >= 2);
    if (m_v) begin
      chk("out_taken", out_taken, m_tk);
      chk("out_illegal", out_illegal, m_il);
      chk("out_mispredict", out_mispredict, m_mp);
      chk("out_redirect_pc", out_redirect_pc, m_rd);
    end
`ifdef BRU_STATS_EN
    chk("stat_branches", stat_branches, m_nb);
    chk("stat_mispredicts", stat_mispredicts, m_nm);
`else
    chk("stat_branches", stat_branches, 0);
    chk("stat_mispredicts", stat_mispredicts, 0);
`endif
  endtask

  // Called right at the rising edge with the inputs that edge sampled.
  task automatic model_step();
    bit retire, acc, tk, il;
    logic [63:0] sum;
    retire = m_v && out_ready;
    acc    = in_valid && (!m_v || out_ready);
    if (retire) begin
      if (m_nb < 64'hFFFF_FFFF) m_nb++;
      if (m_mp && m_nm < 64'hFFFF_FFFF) m_nm++;
      if (!m_il) begin
        if (m_tk) ctr[m_idx] = (ctr[m_idx] == 3) ? 3 : ctr[m_idx] + 1;
        else      ctr[m_idx] = (ctr[m_idx] == 0) ? 0 : ctr[m_idx] - 1;
      end
    end
    if (acc) begin
      tk = 0; il = 0;
      case (fun3)
        3'd0: tk = (op_a == op_b);
        3'd1: tk = (op_a != op_b);
        3'd4: tk = ($signed(op_a) <  $signed(op_b));
        3'd5: tk = ($signed(op_a) >= $signed(op_b));
        3'd6: tk = (op_a <  op_b);
        3'd7: tk = (op_a >= op_b);
        default: il = 1;
      endcase
      sum   = tk ? ({32'd0, pc} + {32'd0, imm}) : ({32'd0, pc} + 64'd4);
      m_v   = 1; m_tk = tk; m_il = il;
      m_mp  = il || (tk != pred_taken);
      m_rd  = sum[31:0];
      m_idx = tidx(pc);
    end else if (retire) begin
      m_v = 0;
    end
  endtask

  task automatic drv(input bit v, input logic [31:0] p, a, b, im, input logic [2:0] f,
                     input bit pt, input bit ordy, input logic [31:0] qp);
    in_valid = v; pc = p; op_a = a; op_b = b; imm = im; fun3 = f;
    pred_taken = pt; out_ready = ordy; q_pc = qp;
    @(negedge clk);
    check_outs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input logic [31:0] qp);
    drv(0, 0, 0, 0, 0, 3'd0, 0, 1, qp);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check_outs();
    chk("rst_redirect_pc", out_redirect_pc, 0);
    chk("rst_taken", out_taken, 0);
    @(posedge clk); #1;

    // first test-plan branch: equal operands, taken, predicted not-taken
    drv(1, 32'h100, 5, 5, 32'h20, 3'b000, 0, 1, 32'h100);
    chk("tp1_taken", out_taken, 1);
    chk("tp1_mispredict", out_mispredict, 1);
    chk("tp1_redirect", out_redirect_pc, 32'h120);

    // signed vs unsigned less-than on the same operands
    drv(1, 32'h200, 32'hFFFF_FFFF, 1, 32'h10, 3'b100, 1, 1, 32'h200);
    chk("blt_taken", out_taken, 1);
    drv(1, 32'h204, 32'hFFFF_FFFF, 1, 32'h10, 3'b110, 0, 1, 32'h204);
    chk("bltu_taken", out_taken, 0);
    chk("bltu_redirect", out_redirect_pc, 32'h208);
    // redirect wraps modulo 2^32
    drv(1, 32'hFFFF_FFFC, 1, 2, 32'h10, 3'b000, 0, 1, 32'h0);
    chk("wrap_redirect", out_redirect_pc, 32'h0);

    // train pc 0x40 up twice, then down four times
    repeat (2) drv(1, 32'h40, 7, 7, 32'h8, 3'b000, 1, 1, 32'h40);
    idle(32'h40);
    chk("bht_up", q_taken, 1);
    repeat (4) drv(1, 32'h40, 7, 7, 32'h8, 3'b001, 1, 1, 32'h40);
    idle(32'h40);
    chk("bht_down", q_taken, 0);

    // stall with new requests pending, then drain back-to-back
    for (int i = 0; i < 4; i++)
      drv(1, 32'h300 + 32'(i * 4), i, 2, 32'h40, 3'b100, 0, 0, 32'h300);
    chk("stall_ready", in_ready, 0);
    for (int i = 0; i < 4; i++)
      drv(1, 32'h310 + 32'(i * 4), i, 1, 32'h80, 3'b111, 1, 1, 32'h310);
    idle(0);

    // illegal fun3 must not train: make the entry weakly taken first
    drv(1, 32'h48, 1, 1, 32'h4, 3'b000, 1, 1, 32'h48);
    drv(1, 32'h48, 1, 2, 32'h4, 3'b011, 0, 1, 32'h48);
    chk("ill_flag", out_illegal, 1);
    chk("ill_mispredict", out_mispredict, 1);
    chk("ill_redirect", out_redirect_pc, 32'h4C);
    idle(32'h48);
    chk("ill_no_train", q_taken, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom : a + 1);
      drv($urandom_range(0, 9) < 7, 32'h1000 + ($urandom_range(0, 31) << 2), a, b, $urandom,
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7,
          32'h1000 + ($urandom_range(0, 31) << 2));
    end

    // asynchronous reset mid-stream
    drv(1, 32'h1004, 3, 3, 32'h10, 3'b000, 0, 1, 32'h1004);
    in_valid = 0;
    #2 rst = 1;
    #1;
    model_reset();
    chk("arst_valid", out_valid, 0);
    chk("arst_stat_br", stat_branches, 0);
    chk("arst_stat_mp", stat_mispredicts, 0);
    check_outs();
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++)
      drv(1, 32'h40 + ($urandom_range(0, 3) << 2), $urandom_range(0, 3), $urandom_range(0, 3),
          32'h20, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          32'h40 + ($urandom_range(0, 3) << 2));
    idle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
